// File: rtl/collision_detect.sv
// ============================================================================
//  Module   : collision_detect
//  Purpose  : Counts opaque pixels shared by the obstacle and dino layers each
//             frame and ends the game after HIT_FRAMES consecutive hits.
//             Optional overlap highlight: define COLLISION_MASK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module collision_detect #(
    parameter int          H_LAST     = 639,
    parameter int          V_LAST     = 479,
    parameter logic [11:0] TRANSP     = 12'hFFF,
    parameter int          THRESH     = 4,
    parameter int          HIT_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdn,
    input  logic [9:0]  col_addr,
    input  logic [8:0]  row_addr,
    input  logic [11:0] obs_px,
    input  logic [11:0] dino_px,
    input  logic        start,
    output logic        running,
    output logic        game_over,
    output logic        hit,
    output logic [15:0] frame_cnt,
    output logic [11:0] mask_px
);

    localparam logic [1:0]  c_IDLE   = 2'd0;
    localparam logic [1:0]  c_RUN    = 2'd1;
    localparam logic [1:0]  c_OVER   = 2'd2;
    localparam logic [9:0]  c_H_LAST = H_LAST[9:0];
    localparam logic [8:0]  c_V_LAST = V_LAST[8:0];
    localparam logic [15:0] c_THRESH = THRESH[15:0];
    localparam logic [3:0]  c_HIT    = HIT_FRAMES[3:0];

    logic        r_rdn_q;
    logic [9:0]  r_col_q;
    logic [8:0]  r_row_q;
    logic [11:0] r_obs_q;
    logic [11:0] r_dino_q;
    logic        r_ov;
    logic        r_fstart;
    logic        r_fend;
    logic [1:0]  r_state;
    logic [15:0] r_acc;
    logic [3:0]  r_consec;
    logic        r_armed;
    logic        r_hit;
    logic [15:0] r_frame_cnt;

    logic [15:0] w_base;
    logic [16:0] w_sum;
    logic [15:0] w_total;
    logic [3:0]  w_consec_nxt;
    logic        w_armed_now;

    // A frame-start pixel opens a fresh frame, so it is added to zero.
    assign w_base       = r_fstart ? 16'd0 : r_acc;
    assign w_sum        = {1'b0, w_base} + {16'd0, r_ov};
    assign w_total      = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    assign w_consec_nxt = r_consec + 4'd1;
    assign w_armed_now  = r_armed | r_fstart;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdn_q     <= 1'b1;
            r_col_q     <= 10'd0;
            r_row_q     <= 9'd0;
            r_obs_q     <= TRANSP;
            r_dino_q    <= TRANSP;
            r_ov        <= 1'b0;
            r_fstart    <= 1'b0;
            r_fend      <= 1'b0;
            r_state     <= c_IDLE;
            r_acc       <= 16'd0;
            r_consec    <= 4'd0;
            r_armed     <= 1'b0;
            r_hit       <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_rdn_q  <= rdn;
            r_col_q  <= col_addr;
            r_row_q  <= row_addr;
            r_obs_q  <= obs_px;
            r_dino_q <= dino_px;
            r_ov     <= ~r_rdn_q & (r_obs_q != TRANSP) & (r_dino_q != TRANSP);
            r_fstart <= ~r_rdn_q & (r_col_q == 10'd0) & (r_row_q == 9'd0);
            r_fend   <= ~r_rdn_q & (r_col_q == c_H_LAST) & (r_row_q == c_V_LAST);
            r_hit    <= 1'b0;

            // start overrides everything, including a coincident frame end
            if (start) begin
                r_state  <= c_RUN;
                r_acc    <= 16'd0;
                r_consec <= 4'd0;
                r_armed  <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_acc    <= 16'd0;
                        r_consec <= 4'd0;
                        r_armed  <= 1'b0;
                    end
                    c_RUN: begin
                        if (w_armed_now) begin
                            r_armed <= 1'b1;
                            if (r_fend) begin
                                r_frame_cnt <= w_total;
                                r_acc       <= 16'd0;
                                if (w_total >= c_THRESH) begin
                                    r_consec <= w_consec_nxt;
                                    if (w_consec_nxt == c_HIT) begin
                                        r_state <= c_OVER;
                                        r_hit   <= 1'b1;
                                    end
                                end else begin
                                    r_consec <= 4'd0;
                                end
                            end else begin
                                r_acc <= w_total;
                            end
                        end
                    end
                    c_OVER: begin
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    assign running   = (r_state == c_RUN);
    assign game_over = (r_state == c_OVER);
    assign hit       = r_hit;
    assign frame_cnt = r_frame_cnt;

`ifdef COLLISION_MASK_EN
    assign mask_px = (r_ov && ((r_state == c_RUN) || (r_state == c_OVER))) ? 12'h00F : TRANSP;
`else
    assign mask_px = TRANSP;
`endif

endmodule

`default_nettype wire

// File: tb/tb_collision_detect.sv
// ============================================================================
//  Module   : tb_collision_detect
//  Purpose  : Randomized frame stimulus for collision_detect on a reduced
//             16x8 visible raster, checked against a frame-rule model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collision_detect;

    localparam int          H_LAST     = 15;
    localparam int          V_LAST     = 7;
    localparam int          H_TOT      = 20;
    localparam int          V_TOT      = 10;
    localparam int          THRESH     = 4;
    localparam int          HIT_FRAMES = 2;
    localparam int          NVIS       = (H_LAST + 1) * (V_LAST + 1);
    localparam logic [11:0] TRANSP     = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdn = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  col_addr = 10'd0;
    logic [8:0]  row_addr = 9'd0;
    logic [11:0] obs_px = 12'hFFF;
    logic [11:0] dino_px = 12'hFFF;
    logic        running;
    logic        game_over;
    logic        hit;
    logic [15:0] frame_cnt;
    logic [11:0] mask_px;

    collision_detect #(
        .H_LAST(H_LAST), .V_LAST(V_LAST), .TRANSP(TRANSP),
        .THRESH(THRESH), .HIT_FRAMES(HIT_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .rdn(rdn), .col_addr(col_addr), .row_addr(row_addr),
        .obs_px(obs_px), .dino_px(dino_px), .start(start),
        .running(running), .game_over(game_over), .hit(hit),
        .frame_cnt(frame_cnt), .mask_px(mask_px)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        running;
        logic        game_over;
        logic        hit;
        logic [15:0] frame_cnt;
        logic [11:0] mask;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   hits_seen = 0;
    int   hits_expected = 0;

    // Game model: 0 idle, 1 playing, 2 game over
    int m_state = 0;
    int m_acc = 0;
    int m_consec = 0;
    int m_fc = 0;
    bit m_armed = 0;
    bit m_hit = 0;
    // pixel events from one and two cycles ago {ov, frame start, frame end}
    bit [2:0] d1 = 3'b000;
    bit [2:0] d2 = 3'b000;

    function automatic logic [11:0] opaque();
        return 12'($urandom_range(0, 12'hFFE));
    endfunction

    task automatic drive(input bit r, input bit s, input bit vis, input int row,
                         input int col, input bit want_ov);
        logic [11:0] o;
        logic [11:0] d;
        bit [2:0]    ev;
        exp_t        e;
        int          k;
        @(posedge clk);
        #1;
        if (vis && want_ov) begin
            o = opaque();
            d = opaque();
        end else if (vis) begin
            k = $urandom_range(0, 2);
            o = (k == 1) ? opaque() : TRANSP;
            d = (k == 0) ? opaque() : TRANSP;
        end else begin
            o = opaque();
            d = opaque();
        end
        rst      = r;
        start    = s;
        rdn      = ~vis;
        row_addr = 9'(row);
        col_addr = 10'(col);
        obs_px   = o;
        dino_px  = d;

        ev[2] = vis && (o != TRANSP) && (d != TRANSP);
        ev[1] = vis && (row == 0) && (col == 0);
        ev[0] = vis && (row == V_LAST) && (col == H_LAST);

        m_hit = 0;
        if (r) begin
            m_state = 0; m_acc = 0; m_consec = 0; m_fc = 0; m_armed = 0;
        end else if (s) begin
            m_state = 1; m_acc = 0; m_consec = 0; m_armed = 0;
        end else if (m_state == 0) begin
            m_acc = 0; m_consec = 0; m_armed = 0;
        end else if (m_state == 1) begin
            if (d2[1]) begin
                m_armed = 1;
                m_acc = 0;
            end
            if (m_armed) begin
                m_acc = (m_acc + d2[2] > 65535) ? 65535 : m_acc + d2[2];
                if (d2[0]) begin
                    m_fc = m_acc;
                    m_acc = 0;
                    m_consec = (m_fc >= THRESH) ? m_consec + 1 : 0;
                    if (m_consec == HIT_FRAMES) begin
                        m_state = 2;
                        m_hit = 1;
                        hits_expected++;
                    end
                end
            end
        end

        e.due       = cyc;
        e.running   = (m_state == 1);
        e.game_over = (m_state == 2);
        e.hit       = m_hit;
        e.frame_cnt = 16'(m_fc);
`ifdef COLLISION_MASK_EN
        e.mask      = (d1[2] && m_state != 0) ? 12'h00F : TRANSP;
`else
        e.mask      = TRANSP;
`endif
        q.push_back(e);
        cyc++;

        d2 = r ? 3'b000 : d1;
        d1 = r ? 3'b000 : ev;
    endtask

    task automatic run_frame(input int n_ov, input int start_row, input bit start_fend,
                             input int rst_row, input int min_row);
        bit ovmap[NVIS];
        int placed;
        int idx;
        bit vis;
        bit s;
        foreach (ovmap[i]) ovmap[i] = 0;
        placed = 0;
        while (placed < n_ov) begin
            idx = $urandom_range(min_row * (H_LAST + 1), NVIS - 1);
            if (!ovmap[idx]) begin
                ovmap[idx] = 1;
                placed++;
            end
        end
        for (int r = 0; r < V_TOT; r++) begin
            for (int c = 0; c < H_TOT; c++) begin
                vis = (r <= V_LAST) && (c <= H_LAST);
                s = ((r == start_row) && (c == 0)) ||
                    (start_fend && (r == V_LAST) && (c == H_LAST + 2));
                drive((r == rst_row) && (c == 5), s, vis, r, c,
                      vis ? ovmap[r * (H_LAST + 1) + c] : 1'b0);
            end
        end
    endtask

    // Monitor: outputs after the edge closing cycle t are visible from cycle t+1
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (hit === 1'b1) hits_seen++;
            while (q.size() > 0 && q[0].due <= cyc - 2) begin
                e = q.pop_front();
                checks++;
                if (running !== e.running || game_over !== e.game_over || hit !== e.hit ||
                    frame_cnt !== e.frame_cnt || mask_px !== e.mask) begin
                    errors++;
                    if (errors <= 30)
                        $display("FAIL outputs cycle %0d: got run=%b over=%b hit=%b cnt=%0d mask=%h, expected run=%b over=%b hit=%b cnt=%0d mask=%h",
                                 e.due, running, game_over, hit, frame_cnt, mask_px,
                                 e.running, e.game_over, e.hit, e.frame_cnt, e.mask);
                end
            end
        end
    end

    initial begin
        int n;
        int sr;
        int rr;
        bit sf;
        for (int i = 0; i < 4; i++) drive(1, 0, 0, V_LAST + 1, 0, 0);
        run_frame(3, -1, 0, -1, 0);              // idle: nothing counted
        run_frame(2, V_LAST + 1, 0, -1, 0);      // start during blanking
        run_frame(0, -1, 0, -1, 0);              // clean frame
        for (int i = 0; i < 5; i++) run_frame(3, -1, 0, -1, 0);
        run_frame(4, -1, 0, -1, 0);
        run_frame(4, -1, 0, -1, 0);              // second hit frame -> game over
        run_frame(5, -1, 0, -1, 0);              // frozen
        run_frame(4, -1, 1, -1, 0);              // start together with frame end
        run_frame(4, -1, 0, -1, 0);
        run_frame(0, -1, 0, -1, 0);
        run_frame(4, -1, 0, -1, 0);
        run_frame(4, -1, 0, -1, 0);
        run_frame(3, -1, 0, 2, 0);               // reset mid-frame
        run_frame(10, 3, 0, -1, 3);              // partial frame ignored
        run_frame(4, -1, 0, -1, 0);
        run_frame(6, -1, 0, -1, 0);
        for (int i = 0; i < 24; i++) begin
            n  = $urandom_range(0, 7);
            sr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, V_TOT - 1)) : -1;
            sf = ($urandom_range(0, 14) == 0);
            rr = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, V_TOT - 1)) : -1;
            if (m_state != 1 && sr < 0) sr = V_LAST + 1;
            run_frame(n, sr, sf, rr, 0);
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 0, V_LAST + 1, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (hits_seen != hits_expected) begin
            errors++;
            $display("FAIL hit_count: got %0d pulses, expected %0d", hits_seen, hits_expected);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
